irq_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the CP0 block. It gathers up to N_SRC external interrupt lines and latches them as pending. It applies a software-written mask and selects the highest-priority request. It presents a single interrupt level to CP0's external interrupt input, then tracks the request until CP0 takes it and the handler signals end-of-interrupt. Software configures and inspects it through a small register port written from the EXE stage.

---
 rtl/irq_ctrl_if.sv | 25 ++
 rtl/irq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// irq_ctrl bus: software register port from EXE plus the CP0 handshake.
// The controller sits on the slave side; the core/CP0 side is the master.
interface irq_ctrl_if #(
    parameter int ID_W = 3
);
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            taken;
    logic            eoi;
    logic            ir_out;
    logic [ID_W-1:0] ir_id;
    logic            busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, taken, eoi,
        input  cfg_rdata, ir_out, ir_id, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, taken, eoi,
        output cfg_rdata, ir_out, ir_id, busy
    );
endinterface

// File: rtl/irq_ctrl.sv
// Priority interrupt controller feeding CP0's external interrupt input.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on irq_src.
module irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    irq_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] s_prev;
    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] edge_r;
    logic [N_SRC-1:0] epend;
    logic [N_SRC-1:0] epend_next;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] take;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  win;
    logic             any_req;
    logic             id_req;
    logic             ir_out;
    logic             busy;
    logic             unused_wdata;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = irq_src;
`endif

    // Only edge sources keep state; level sources mirror s directly.
    assign pend    = (edge_r & epend) | (~edge_r & s);
    assign req     = pend & mask_r;
    assign any_req = |req;
    assign id_req  = req[id_r];
    assign rise    = s & ~s_prev;

    assign w1c = (bus.cfg_we && bus.cfg_addr == 2'd1)
               ? bus.cfg_wdata[N_SRC-1:0] : '0;

    assign unused_wdata = ^bus.cfg_wdata;

    always_comb begin
        take = '0;
        for (int i = 0; i < N_SRC; i++) begin
            take[i] = (state == ASSERT) && bus.taken
                    && (id_r == ID_W'(i));
        end
    end

    // A fresh edge beats a clear landing in the same cycle.
    assign epend_next = edge_r & (rise | (epend & ~(w1c | take)));

    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r <= '0;
            edge_r <= '0;
            epend  <= '0;
            s_prev <= '0;
            id_r   <= '0;
        end else begin
            if (bus.cfg_we && bus.cfg_addr == 2'd0) begin
                mask_r <= bus.cfg_wdata[N_SRC-1:0];
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd3) begin
                edge_r <= bus.cfg_wdata[N_SRC-1:0];
            end
            epend  <= epend_next;
            s_prev <= s;
            if (state == IDLE && any_req) begin
                id_r <= win;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (bus.taken) begin
                    state_next = SERVICE;
                end else if (!id_req) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (bus.eoi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ir_out = 1'b0;
        busy   = 1'b0;
        unique case (state)
            IDLE: begin
                ir_out = 1'b0;
                busy   = 1'b0;
            end
            ASSERT: begin
                ir_out = 1'b1;
                busy   = 1'b1;
            end
            SERVICE: begin
                ir_out = 1'b0;
                busy   = 1'b1;
            end
            default: begin
                ir_out = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.cfg_rdata = '0;
        unique case (bus.cfg_addr)
            2'd0: bus.cfg_rdata = 32'(mask_r);
            2'd1: bus.cfg_rdata = 32'(pend);
            2'd2: bus.cfg_rdata = {busy, 23'b0, 8'(id_r)};
            2'd3: bus.cfg_rdata = 32'(edge_r);
            default: bus.cfg_rdata = '0;
        endcase
    end

    assign bus.ir_out = ir_out;
    assign bus.busy   = busy;
    assign bus.ir_id  = id_r;
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations,
// then random traffic against a behavioural model checked every cycle.
`timescale 1ns/1ps
module tb_irq_ctrl;
    localparam int N   = 8;
    localparam int IDW = 3;
`ifdef IRQ_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic         go = 1'b0;
    int           checks = 0;
    int           errors = 0;

    irq_ctrl_if #(.ID_W(IDW)) bus ();

    irq_ctrl #(.N_SRC(N), .ID_W(IDW)) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_src(irq_src),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: st 0=idle 1=asserting 2=in service; pend holds edge bits only.
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] m_edge = '0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_sp   = '0;
    logic [N-1:0] m_s1   = '0;
    logic [N-1:0] m_s2   = '0;
    int           m_st   = 0;
    int           m_id   = 0;

    function automatic logic [N-1:0] m_s();
`ifdef IRQ_SYNC_EN
        return m_s2;
`else
        return irq_src;
`endif
    endfunction

    function automatic logic [N-1:0] pview();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i] = m_edge[i] ? m_pend[i] : m_s()[i];
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [N-1:0] s;
        logic [N-1:0] p;
        logic [N-1:0] rq;
        logic [N-1:0] np;
        int           ns;
        int           nid;
        bit           up;
        bit           clr;
        if (rst) begin
            m_mask <= '0;
            m_edge <= '0;
            m_pend <= '0;
            m_sp   <= '0;
            m_s1   <= '0;
            m_s2   <= '0;
            m_st   <= 0;
            m_id   <= 0;
        end else begin
            s   = m_s();
            p   = pview();
            rq  = p & m_mask;
            ns  = m_st;
            nid = m_id;
            if (m_st == 0) begin
                if (rq != 0) begin
                    for (int i = N - 1; i >= 0; i--) begin
                        if (rq[i]) nid = i;
                    end
                    ns = 1;
                end
            end else if (m_st == 1) begin
                if (bus.taken) ns = 2;
                else if (!rq[m_id]) ns = 0;
            end else if (bus.eoi) begin
                ns = 0;
            end
            for (int i = 0; i < N; i++) begin
                up  = s[i] && !m_sp[i];
                clr = (bus.cfg_we && bus.cfg_addr == 2'd1 && bus.cfg_wdata[i])
                   || (m_st == 1 && bus.taken && m_id == i);
                np[i] = m_edge[i] && (up || (m_pend[i] && !clr));
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd0) m_mask <= bus.cfg_wdata[N-1:0];
            if (bus.cfg_we && bus.cfg_addr == 2'd3) m_edge <= bus.cfg_wdata[N-1:0];
            m_pend <= np;
            m_sp   <= s;
            m_s1   <= irq_src;
            m_s2   <= m_s1;
            m_st   <= ns;
            m_id   <= nid;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] exp_rd;
        if (go) begin
            case (bus.cfg_addr)
                2'd0:    exp_rd = 32'(m_mask);
                2'd1:    exp_rd = 32'(pview());
                2'd2:    exp_rd = {m_st != 0, 23'b0, 8'(m_id)};
                default: exp_rd = 32'(m_edge);
            endcase
            chk("cyc_ir_out", bus.ir_out, m_st == 1);
            chk("cyc_busy", bus.busy, m_st != 0);
            chk("cyc_ir_id", 32'(bus.ir_id), m_id);
            chk("cyc_rdata", bus.cfg_rdata, exp_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.cfg_addr = a;
        #1;
        d = bus.cfg_rdata;
    endtask

    task automatic pulse(input logic [N-1:0] v, output int n);
        irq_src = v;
        tick();
        n = 1;
        irq_src = '0;
        while (!bus.ir_out && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic take_eoi();
        bus.taken = 1'b1;
        tick();
        bus.taken = 1'b0;
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    logic [31:0] d;
    int          n;
    bit          seen;

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = '0;
        bus.taken     = 1'b0;
        bus.eoi       = 1'b0;
        #1 rst = 1'b1;
        tick();
        go = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk("reset_rdata", d, 32'h0);
            tick();
        end
        chk("reset_ir_out", bus.ir_out, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_ir_id", 32'(bus.ir_id), 0);
        rst = 1'b0;
        tick();

        // single edge source
        wr(2'd3, 32'h01);
        wr(2'd0, 32'h01);
        pulse(8'h01, n);
        chk("t1_latency", n, 2 + SD);
        chk("t1_ir_id", 32'(bus.ir_id), 0);
        rd(2'd2, d);
        chk("t1_cause", d, 32'h8000_0000);
        bus.taken = 1'b1;
        tick();
        bus.taken = 1'b0;
        chk("t1_taken_ir_out", bus.ir_out, 1'b0);
        chk("t1_taken_busy", bus.busy, 1'b1);
        rd(2'd1, d);
        chk("t1_pending_clr", d, 32'h0);
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        chk("t1_eoi_busy", bus.busy, 1'b0);

        // two simultaneous edges, priority and one-cycle gap
        wr(2'd3, 32'hFF);
        wr(2'd0, 32'hFF);
        pulse(8'h24, n);
        chk("t2_latency", n, 2 + SD);
        chk("t2_first_id", 32'(bus.ir_id), 2);
        take_eoi();
        chk("t2_gap_low", bus.ir_out, 1'b0);
        tick();
        chk("t2_reassert", bus.ir_out, 1'b1);
        chk("t2_second_id", 32'(bus.ir_id), 5);
        take_eoi();

        // level source
        wr(2'd3, 32'h00);
        wr(2'd0, 32'h08);
        pulse(8'h08, n);
        irq_src = 8'h08;
        chk("t3_assert", bus.ir_out, 1'b1);
        chk("t3_id", 32'(bus.ir_id), 3);
        take_eoi();
        chk("t3_eoi_low", bus.ir_out, 1'b0);
        tick();
        chk("t3_reassert", bus.ir_out, 1'b1);
        chk("t3_reassert_id", 32'(bus.ir_id), 3);
        irq_src = '0;
        n = 0;
        while (bus.ir_out && n < 20) begin
            tick();
            n++;
        end
        chk("t3_drop_delay", n, 1 + SD);
        chk("t3_drop_idle", bus.busy, 1'b0);

        // mask clear during assert
        wr(2'd3, 32'h02);
        wr(2'd0, 32'h02);
        pulse(8'h02, n);
        chk("t4_assert", bus.ir_out, 1'b1);
        wr(2'd0, 32'h00);
        chk("t4_still_high", bus.ir_out, 1'b1);
        tick();
        chk("t4_dropped", bus.ir_out, 1'b0);
        rd(2'd1, d);
        chk("t4_pending_kept", d, 32'h02);
        wr(2'd0, 32'h02);
        chk("t4_idle_gap", bus.ir_out, 1'b0);
        tick();
        chk("t4_reassert", bus.ir_out, 1'b1);
        take_eoi();

        // W1C colliding with a new edge
        wr(2'd0, 32'h00);
        wr(2'd3, 32'h10);
        irq_src = 8'h10;
        tick();
        irq_src = '0;
        repeat (SD + 1) tick();
        rd(2'd1, d);
        chk("t5_pending_set", d, 32'h10);
        irq_src = 8'h10;
        repeat (SD) tick();
        wr(2'd1, 32'h10);
        rd(2'd1, d);
        chk("t5_set_wins", d, 32'h10);
        irq_src = '0;
        repeat (SD + 1) tick();
        wr(2'd1, 32'h10);
        rd(2'd1, d);
        chk("t5_w1c", d, 32'h0);

        // asynchronous reset in service
        wr(2'd3, 32'h03);
        wr(2'd0, 32'h03);
        pulse(8'h03, n);
        chk("t6_id", 32'(bus.ir_id), 0);
        bus.taken = 1'b1;
        tick();
        bus.taken = 1'b0;
        chk("t6_service", bus.busy, 1'b1);
        bus.cfg_addr = 2'd0;
        rst = 1'b1;
        #1;
        chk("t6_rst_ir_out", bus.ir_out, 1'b0);
        chk("t6_rst_busy", bus.busy, 1'b0);
        chk("t6_rst_mask", bus.cfg_rdata, 32'h0);
        bus.cfg_addr = 2'd1;
        #1;
        chk("t6_rst_pending", bus.cfg_rdata, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        irq_src = 8'h01;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.ir_out) seen = 1'b1;
        end
        chk("t6_no_irq_masked", seen, 1'b0);
        irq_src = '0;
        repeat (SD + 1) tick();
        wr(2'd3, 32'h01);
        wr(2'd0, 32'h01);
        pulse(8'h01, n);
        chk("t6_after_rewrite", bus.ir_out, 1'b1);
        take_eoi();

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            bus.taken     = ($urandom_range(0, 2) == 0);
            bus.eoi       = ($urandom_range(0, 2) == 0);
            bus.cfg_we    = ($urandom_range(0, 11) == 0);
            bus.cfg_addr  = 2'($urandom);
            bus.cfg_wdata = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end
        bus.cfg_we = 1'b0;
        bus.taken  = 1'b0;
        bus.eoi    = 1'b0;
        tick();
        go = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
